// File: rtl/green_pkg.sv
// Shared encodings, field bounds and state type for the green instruction sequencer.
// GREEN_SEQ_STEP_EN adds the single-step STALL state.
package green_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ZNC_W   = 3;

    // Opcode class field and branch-target field within an instruction word
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;
    localparam int unsigned BR_HI  = 7;
    localparam int unsigned BR_LO  = 0;

    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;
    localparam logic [OPC_W-1:0] OPC_ST   = 4'h3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ZNC_W-1:0]  znc;
    } green_arch_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
`ifdef GREEN_SEQ_STEP_EN
        S_HALT   = 3'd4,
        S_STALL  = 3'd5
`else
        S_HALT   = 3'd4
`endif
    } green_seq_state_t;

endpackage

// File: rtl/green_seq_regs.sv
// Architectural A/B/ZNC state of the green unit, loaded as one word at the end of EXEC.
module green_seq_regs
    import green_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  green_arch_t res,
    output green_arch_t arch
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch <= '0;
        end else if (load) begin
            arch <= res;
        end
    end

endmodule

// File: rtl/green_seq.sv
// Fetch/decode/execute sequencer driving one green execution unit from a synchronous ROM.
// Optional GREEN_SEQ_STEP_EN adds a step input that gates each instruction fetch.
module green_seq
    import green_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef GREEN_SEQ_STEP_EN
    input  logic               step,
`endif
    output logic               busy,
    output logic               halted,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               g_en,
    output logic               g_we,
    output logic [INSTR_W-1:0] g_opcode,
    output logic [DATA_W-1:0]  g_a,
    output logic [DATA_W-1:0]  g_b,
    output logic [ZNC_W-1:0]   g_znc,
    input  logic [DATA_W-1:0]  g_a_res,
    input  logic [DATA_W-1:0]  g_b_res,
    input  logic [ZNC_W-1:0]   g_znc_res,
    input  logic               g_br,
    output logic [PC_W-1:0]    pc
);

    green_seq_state_t    state_q, state_d;
    green_seq_state_t    resume_state;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                busy_d, halted_d, en_d, we_d;
    green_arch_t         arch_res, arch_q;

    // Where the sequencer goes when it is allowed to begin the next instruction
`ifdef GREEN_SEQ_STEP_EN
    assign resume_state = step ? S_FETCH : S_STALL;
`else
    assign resume_state = S_FETCH;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = resume_state;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = imem_data;
                state_d = (imem_data[OPC_HI:OPC_LO] == OPC_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                pc_d    = g_br ? PC_W'(ir_q[BR_HI:BR_LO]) : pc_q + PC_W'(1);
                state_d = resume_state;
            end
`ifdef GREEN_SEQ_STEP_EN
            S_STALL: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status and green strobes are registered from the next state
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
        en_d     = (state_d == S_EXEC);
        we_d     = en_d && (ir_d[OPC_HI:OPC_LO] == OPC_ST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            g_en    <= 1'b0;
            g_we    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            busy    <= busy_d;
            halted  <= halted_d;
            g_en    <= en_d;
            g_we    <= we_d;
        end
    end

    assign arch_res = '{a: g_a_res, b: g_b_res, znc: g_znc_res};

    green_seq_regs u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q == S_EXEC),
        .res   (arch_res),
        .arch  (arch_q)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign g_opcode  = ir_q;
    assign g_a       = arch_q.a;
    assign g_b       = arch_q.b;
    assign g_znc     = arch_q.znc;

endmodule

// File: doc/green_seq.md
# green_seq

Instruction sequencer for the `green` execution unit. Fetches 16-bit opcodes from a synchronous instruction ROM, presents them to `green` with the correct enable/write-enable timing, holds the architectural A/B/ZNC state between instructions, and advances or redirects the 8-bit program counter using `green`'s branch result. It sits between the top level and one `green` instance; `green` itself is unchanged.

## Interface
- `PC_W`, default 8: program-counter and instruction-address width.
- `RESET_PC`, default 8'h00: PC value after reset and after every `start`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active low.
- `start`  in  1  single-cycle pulse; begins execution at `RESET_PC` from IDLE or HALT.
- `busy`  out  1  high while a program is running (not IDLE, not HALT).
- `halted`  out  1  high in HALT state.
- `imem_addr`  out  PC_W  instruction ROM address.
- `imem_data`  in  16  ROM data, valid one cycle after `imem_addr`.
- `g_en`, `g_we`  out  1  drive `green` en / WE.
- `g_opcode`  out  16  drive `green` opCode (instruction register).
- `g_a`, `g_b`  out  16  drive `green` A_in / B_in (architectural A, B).
- `g_znc`  out  3  drive `green` ZNC_in.
- `g_a_res`, `g_b_res`  in  16  from `green` A_out / B_out.
- `g_znc_res`  in  3  from `green` ZNC_out.
- `g_br`  in  1  from `green` BR_out.
- `pc`  out  PC_W  current program counter (debug).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE --start--> FETCH (PC := RESET_PC). HALT --start--> FETCH (PC := RESET_PC; A/B/ZNC preserved).
- FETCH: `imem_addr` = PC. -> DECODE.
- DECODE: IR := `imem_data`. If IR[15:12] == OPC_HALT -> HALT (PC unchanged), else -> EXEC.
- EXEC: `g_en` = 1; `g_we` = 1 iff IR[15:12] == OPC_ST. At the end of EXEC: A := `g_a_res`, B := `g_b_res`, ZNC := `g_znc_res`; PC := `g_br` ? IR[7:0] : PC + 1. -> FETCH.
- PC increment wraps 8'hFF -> 8'h00 silently. A branch target of 8'hFF is legal.
- `start` while busy is ignored. `start` in the same cycle as the DECODE->HALT transition is ignored; a new pulse is required.
- `g_opcode` always equals IR. `g_en`/`g_we` are low in every state except EXEC.
- Reset values: state IDLE, PC = RESET_PC, IR = 0, A = B = 0, ZNC = 0, `busy` = `halted` = `g_en` = `g_we` = 0.
- Reset asserted mid-instruction (including EXEC) aborts immediately. No partial A/B/ZNC/PC update survives. `g_we` drops asynchronously with reset.

## Timing
- 3 cycles per non-halt instruction: FETCH, DECODE, EXEC. HALT is reached 2 cycles after its FETCH.
- `g_we` is high for exactly the EXEC cycle. `green`'s RAM writes on the falling edge inside that cycle. Data and address are stable from the EXEC rising edge.
- Results are sampled at the rising edge that ends EXEC. `green` is combinational apart from its RAM, so its outputs have settled by then.
- All outputs are registered or decoded from state only, with no combinational path from inputs.
- First `imem_addr` is valid in the cycle after `start`.

## Configuration
- `GREEN_SEQ_STEP_EN`: when defined, adds input `step` (1 bit). FETCH is entered from EXEC (or from IDLE/HALT via `start`) only on a cycle where `step` is high; otherwise the sequencer waits in a STALL state with `busy` = 1 and `g_en` = 0. This gives one instruction per `step` pulse.
- Without the macro: no `step` port, no STALL state, free-running as above.

## Structure
- Package `green_pkg`:
  - opcode class field bounds [15:12];
  - constants OPC_HALT = 4'hF, OPC_ST = 4'h3;
  - branch-target field [7:0];
  - state enum `green_seq_state_t`.
- No sub-module is required. An optional `green_seq_regs` holding A/B/ZNC with a single load enable is acceptable. The bench instantiates `green_seq` plus a real `green`.

## Test plan
- Reset, then `start`; ROM[0] = ST, ROM[1] = HALT: `g_we` = 1 for exactly one cycle, 2 cycles after `start`. `halted` = 1 at cycle 5. PC = 1.
- Straight-line sequence of 3 INC ops from A = 0: A = 3 after 9 cycles. PC = 3. ZNC matches `green`'s flags.
- Taken branch at 0x05 with target 0x20: next `imem_addr` = 0x20. Not-taken case (`g_br` = 0): next `imem_addr` = 0x06.
- PC at 0xFF with a non-branch op: next FETCH address = 0x00, no error state.
- `rst_n` low during EXEC of a ST: `g_we` falls immediately. After release: state IDLE, A = B = ZNC = 0, PC = 0. `start` during busy has no effect.
- With `GREEN_SEQ_STEP_EN`: `step` held low after the first instruction leaves PC frozen at 1. One `step` pulse advances exactly one instruction.
